// File: rtl/spi_sec_pkg.sv
// spi_sec_pkg
//   Shared definitions for the SPI secondary:
//   - state_e  : FSM state encoding (ST_IDLE, ST_ACTIVE)
//   - *_IDLE_LVL : levels the input synchronizers reset to, matching an
//                  idle mode-0 bus (cs deasserted high, sclk low, mosi low)
package spi_sec_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic CS_IDLE_LVL   = 1'b1;
  localparam logic SCLK_IDLE_LVL = 1'b0;
  localparam logic MOSI_IDLE_LVL = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Multi-flop synchronizer for one asynchronous input, followed by a history
//   flop used for edge detection. rise/fall are single-cycle strobes.
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     din        asynchronous input
//     level      synchronized level (last synchronizer stage)
//     rise/fall  1-cycle strobes when level changes 0->1 / 1->0
module spi_sync_edge
  import spi_sec_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_LVL}};
      hist_q <= IDLE_LVL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_secondary.sv
// spi_secondary
//   SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first, active-low cs.
//   sclk/cs/mosi are oversampled in the clk domain; words may follow each
//   other back-to-back inside one cs assertion.
//   Ports:
//     clk, rst            system clock, synchronous active-high reset
//     sclk, cs, mosi      SPI bus inputs (asynchronous to clk)
//     miso                serial data out, 0 while not selected
//     tx_data, tx_wr      tx_wr strobe loads tx_data into the transmit buffer
//     rx_data, rx_valid   last complete word; rx_valid held until rx_rd
//     rx_rd               strobe acknowledging rx_data
//     done                1-cycle pulse per completed word
//     busy                high while a transfer is active
//     ovr                 sticky overrun flag (only when SPI_SEC_OVR_EN is defined)
//   Handshake: tx_wr and rx_rd are single-cycle strobes sampled on posedge clk;
//   rx_valid is a level that rises with done and falls on rx_rd, except that a
//   word completing in the same cycle as rx_rd keeps rx_valid high.
//   Build option: define SPI_SEC_OVR_EN to add the ovr port and its logic.
module spi_secondary
  import spi_sec_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_wr,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  output logic              done,
`ifdef SPI_SEC_OVR_EN
  output logic              busy,
  output logic              ovr
`else
  output logic              busy
`endif
);

  localparam int            CW       = $clog2(DWIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

  // Synchronized bus signals
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;

  spi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .IDLE_LVL (SCLK_IDLE_LVL)
  ) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .IDLE_LVL (CS_IDLE_LVL)
  ) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi goes through the same number of stages as sclk so the sampled bit
  // lines up with the synchronized rising edge.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // State
  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  // warm_q fills with ones after reset; until its top bit is set the cs
  // synchronizer still shows its reset value rather than the pin, so that
  // value must not arm the FSM.
  logic [SYNC_STAGES:0] warm_q, warm_d;
  logic [DWIDTH-1:0] tx_buf_q, tx_buf_d;
  // miso_q carries the bit on the wire; txsh_q holds the bits still to follow.
  logic [DWIDTH-2:0] txsh_q, txsh_d;
  // rxsh_q holds the bits received so far in the current word.
  logic [DWIDTH-2:0] rxsh_q, rxsh_d;
  logic [DWIDTH-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              miso_q, miso_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              last_q, last_d;

  logic [DWIDTH-1:0] tx_word;
  logic [DWIDTH-1:0] rx_word;
  logic              word_done;

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};
    state_d     = state_q;
    armed_d     = armed_q;
    tx_buf_d    = tx_buf_q;
    txsh_d      = txsh_q;
    rxsh_d      = rxsh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    done_d      = 1'b0;
    miso_d      = miso_q;
    bit_cnt_d   = bit_cnt_q;
    last_d      = last_q;
    word_done   = 1'b0;

    // A write in the same cycle as a word load is used directly.
    tx_word = tx_wr ? tx_data : tx_buf_q;
    rx_word = {rxsh_q, mosi_s};

    if (tx_wr) tx_buf_d = tx_data;
    if (rx_rd) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        last_d    = 1'b0;
        if (cs_s && warm_q[SYNC_STAGES]) armed_d = 1'b1;
        if (cs_fall && armed_q) begin
          state_d = ST_ACTIVE;
          armed_d = 1'b0;
          miso_d  = tx_word[DWIDTH-1];
          txsh_d  = tx_word[DWIDTH-2:0];
        end
      end

      ST_ACTIVE: begin
        if (sclk_rise) begin
          rxsh_d    = rx_word[DWIDTH-2:0];
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            done_d     = 1'b1;
            bit_cnt_d  = '0;
            last_d     = 1'b1;
            word_done  = 1'b1;
          end
        end else if (sclk_fall) begin
          if (last_q) begin
            miso_d = tx_word[DWIDTH-1];
            txsh_d = tx_word[DWIDTH-2:0];
            last_d = 1'b0;
          end else begin
            miso_d = txsh_q[DWIDTH-2];
            txsh_d = txsh_q << 1;
          end
        end
        // Deselect aborts any partial word; a word finishing on this same
        // cycle has already been committed above.
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          last_d    = 1'b0;
          miso_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SPI_SEC_OVR_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (rx_rd) ovr_d = 1'b0;
    if (word_done && rx_valid_q && !rx_rd) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= {SYNC_STAGES{MOSI_IDLE_LVL}};
      warm_q      <= '0;
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      tx_buf_q    <= '0;
      txsh_q      <= '0;
      rxsh_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
      bit_cnt_q   <= '0;
      last_q      <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      warm_q      <= warm_d;
      state_q     <= state_d;
      armed_q     <= armed_d;
      tx_buf_q    <= tx_buf_d;
      txsh_q      <= txsh_d;
      rxsh_q      <= rxsh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      miso_q      <= miso_d;
      bit_cnt_q   <= bit_cnt_d;
      last_q      <= last_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign done     = done_q;
  assign busy     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_secondary.sv
// tb_spi_secondary
//   Bench for spi_secondary (DWIDTH=8, SYNC_STAGES=2). Acts as the SPI
//   initiator with sclk half-period of 8 clk; all inputs change on negedge clk.
module tb_spi_secondary;

  localparam int HALF = 8;

  logic       clk, rst;
  logic       sclk, cs, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_wr, rx_valid, rx_rd, done, busy;
`ifdef SPI_SEC_OVR_EN
  logic       ovr;
`endif

  spi_secondary #(
    .DWIDTH      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_rd    (rx_rd),
    .done     (done),
`ifdef SPI_SEC_OVR_EN
    .busy     (busy),
    .ovr      (ovr)
`else
    .busy     (busy)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // scoreboard counters
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] v);
    tx_data = v;
    tx_wr   = 1'b1;
    wait_clk(1);
    tx_wr   = 1'b0;
  endtask

  task automatic read_rx();
    rx_rd = 1'b1;
    wait_clk(1);
    rx_rd = 1'b0;
  endtask

  // Shift nbits of mo out MSB first, capturing miso just before each rising
  // edge. ld is done sampled 3 clk after the last rising edge; with rd_last
  // set, rx_rd is driven on the clock edge where that word completes.
  task automatic xfer(input logic [7:0] mo, input int nbits, input logic rd_last,
                      output logic [7:0] mi, output logic ld);
    mi = 8'h00;
    ld = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(HALF);
      mi   = {mi[6:0], miso};
      sclk = 1'b1;
      wait_clk(2);
      rx_rd = rd_last && (i == nbits - 1);
      wait_clk(1);
      ld    = done;
      rx_rd = 1'b0;
      wait_clk(HALF - 3);
      sclk = 1'b0;
    end
  endtask

  task automatic deselect();
    wait_clk(4);
    cs = 1'b1;
    wait_clk(6);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] mi;
  logic       ld;
  int         d0;

  initial begin
    vecs[0] = '{tx: 8'hA5, mo: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'hA5};
    vecs[1] = '{tx: 8'h00, mo: 8'hFF, exp_rx: 8'hFF, exp_miso: 8'h00};
    vecs[2] = '{tx: 8'hFF, mo: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[3] = '{tx: 8'h81, mo: 8'h7E, exp_rx: 8'h7E, exp_miso: 8'h81};
    vecs[4] = '{tx: 8'h5A, mo: 8'hC3, exp_rx: 8'hC3, exp_miso: 8'h5A};

    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);

    // reset state
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
`ifdef SPI_SEC_OVR_EN
    check("rst_ovr", ovr, 0);
`endif
    wait_clk(8);

    // single-word vectors
    for (int i = 0; i < 5; i++) begin
      write_tx(vecs[i].tx);
      wait_clk(2);
      d0 = done_cnt;
      cs = 1'b0;
      xfer(vecs[i].mo, 8, 1'b0, mi, ld);
      wait_clk(4);
      check("vec_busy_active", busy, 1);
      cs = 1'b1;
      wait_clk(6);
      check("vec_rx_data", rx_data, vecs[i].exp_rx);
      check("vec_miso_stream", mi, vecs[i].exp_miso);
      check("vec_rx_valid", rx_valid, 1);
      check("vec_done_latency", ld, 1);
      check("vec_done_count", done_cnt - d0, 1);
      check("vec_busy_idle", busy, 0);
      check("vec_miso_idle", miso, 0);
      read_rx();
      check("vec_rx_valid_clr", rx_valid, 0);
    end

    // two words in one cs, tx buffer refreshed during word 1, no rx_rd
    write_tx(8'h99);
    wait_clk(2);
    d0 = done_cnt;
    cs = 1'b0;
    fork
      xfer(8'h12, 8, 1'b0, mi, ld);
      begin
        wait_clk(30);
        write_tx(8'h55);
      end
    join
    check("b2b_w1_miso", mi, 8'h99);
    check("b2b_w1_rx", rx_data, 8'h12);
    check("b2b_w1_valid", rx_valid, 1);
    xfer(8'h34, 8, 1'b0, mi, ld);
    check("b2b_w2_miso", mi, 8'h55);
    check("b2b_w2_rx", rx_data, 8'h34);
    deselect();
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_valid_held", rx_valid, 1);
`ifdef SPI_SEC_OVR_EN
    check("b2b_ovr_set", ovr, 1);
`endif
    read_rx();
    check("b2b_valid_clr", rx_valid, 0);
`ifdef SPI_SEC_OVR_EN
    check("b2b_ovr_clr", ovr, 0);
`endif

    // rx_rd on the completion edge of the second word; buffer retransmitted
    wait_clk(4);
    cs = 1'b0;
    xfer(8'hC6, 8, 1'b0, mi, ld);
    check("rdc_w1_miso", mi, 8'h55);
    xfer(8'h3A, 8, 1'b1, mi, ld);
    check("rdc_w2_miso", mi, 8'h55);
    check("rdc_done", ld, 1);
    check("rdc_valid_kept", rx_valid, 1);
    check("rdc_rx", rx_data, 8'h3A);
`ifdef SPI_SEC_OVR_EN
    check("rdc_ovr", ovr, 0);
`endif
    deselect();
    read_rx();

    // abort after 5 bits, then a full word
    wait_clk(4);
    d0 = done_cnt;
    cs = 1'b0;
    xfer(8'hFF, 5, 1'b0, mi, ld);
    check("abort_no_done_pulse", ld, 0);
    deselect();
    check("abort_busy", busy, 0);
    check("abort_miso", miso, 0);
    check("abort_rx_kept", rx_data, 8'h3A);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_done_count", done_cnt - d0, 0);
    write_tx(8'h24);
    wait_clk(2);
    cs = 1'b0;
    xfer(8'h81, 8, 1'b0, mi, ld);
    deselect();
    check("post_abort_rx", rx_data, 8'h81);
    check("post_abort_miso", mi, 8'h24);
    read_rx();

    // reset while selected mid-word
    wait_clk(4);
    cs = 1'b0;
    xfer(8'hF0, 3, 1'b0, mi, ld);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    d0 = done_cnt;
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_miso", miso, 0);
`ifdef SPI_SEC_OVR_EN
    check("midrst_ovr", ovr, 0);
`endif
    xfer(8'h1F, 5, 1'b0, mi, ld);
    check("midrst_ignored_busy", busy, 0);
    check("midrst_ignored_miso", miso, 0);
    check("midrst_ignored_valid", rx_valid, 0);
    check("midrst_ignored_done", done_cnt - d0, 0);
    cs = 1'b1;
    wait_clk(8);
    cs = 1'b0;
    xfer(8'h6B, 8, 1'b0, mi, ld);
    deselect();
    check("after_rst_rx", rx_data, 8'h6B);
    check("after_rst_miso", mi, 8'h00);
    check("after_rst_done_count", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
